// File: rtl/window_3x3_buffer_if.sv
// Pixel stream in, 3x3 window stream out, for window_3x3_buffer.
// Latency: none (wires only).
// Backpressure: none; the producer paces the stream with En.
// Ports:
//   En         - pixel valid.
//   Data_In    - one pixel in raster order.
//   Win_Out    - nine packed window pixels, oldest row in the low slices.
//   Out_Valid  - window complete pulse.
//   Frame_Done - last pixel of the frame accepted pulse.
interface window_3x3_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    En;
  logic [DATA_WIDTH-1:0]   Data_In;
  logic [9*DATA_WIDTH-1:0] Win_Out;
  logic                    Out_Valid;
  logic                    Frame_Done;

  modport master (
    output En, Data_In,
    input  Win_Out, Out_Valid, Frame_Done
  );

  modport slave (
    input  En, Data_In,
    output Win_Out, Out_Valid, Frame_Done
  );
endinterface

// File: rtl/window_3x3_buffer.sv
// Builds a sliding 3x3 pixel window over a square raster frame.
// Latency: 1 cycle from pixel acceptance to Win_Out/Out_Valid.
// Backpressure: none; all state holds while En=0.
// Ports:
//   Clk  - single clock, rising edge.
//   Rst  - asynchronous active-high reset.
//   bus  - slave side of window_3x3_buffer_if (En, Data_In in; Win_Out,
//          Out_Valid, Frame_Done out).
module window_3x3_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_SIZE   = 100
) (
  input logic                 Clk,
  input logic                 Rst,
  window_3x3_buffer_if.slave  bus
);

  localparam logic [15:0] LAST = 16'(IMG_SIZE);

  // Position of the next pixel to be accepted, 1-based.
  logic [15:0] col;
  logic [15:0] row;

  logic [DATA_WIDTH-1:0] lb1 [IMG_SIZE];
  logic [DATA_WIDTH-1:0] lb2 [IMG_SIZE];
  logic [DATA_WIDTH-1:0] win [9];

  logic out_valid;
  logic frame_done;

  // IMG_SIZE shifts after a pixel enters, it is at the tail: one row above.
  logic [DATA_WIDTH-1:0] lb1_out;
  logic [DATA_WIDTH-1:0] lb2_out;
  assign lb1_out = lb1[IMG_SIZE-1];
  assign lb2_out = lb2[IMG_SIZE-1];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      col        <= 16'd1;
      row        <= 16'd1;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < IMG_SIZE; k++) begin
        lb1[k] <= '0;
        lb2[k] <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
    end else begin
      // Position qualifiers suppress windows that straddle a row boundary
      // or still contain rows from the previous frame.
      out_valid  <= bus.En && (row >= 16'd3) && (col >= 16'd3);
      frame_done <= bus.En && (row == LAST) && (col == LAST);

      if (bus.En) begin
        if (col == LAST) begin
          col <= 16'd1;
          row <= (row == LAST) ? 16'd1 : row + 16'd1;
        end else begin
          col <= col + 16'd1;
        end

        lb1[0] <= bus.Data_In;
        lb2[0] <= lb1_out;
        for (int k = 1; k < IMG_SIZE; k++) begin
          lb1[k] <= lb1[k-1];
          lb2[k] <= lb2[k-1];
        end

        // Shift each window row left one column, newest column enters at j=2.
        for (int i = 0; i < 3; i++) begin
          win[3*i]   <= win[3*i+1];
          win[3*i+1] <= win[3*i+2];
        end
        win[2] <= lb2_out;
        win[5] <= lb1_out;
        win[8] <= bus.Data_In;
      end
    end
  end

  always_comb begin
    bus.Win_Out = '0;
    for (int k = 0; k < 9; k++) begin
      bus.Win_Out[k*DATA_WIDTH +: DATA_WIDTH] = win[k];
    end
  end

  assign bus.Out_Valid  = out_valid;
  assign bus.Frame_Done = frame_done;

endmodule

// File: tb/tb_window_3x3_buffer.sv
module tb_window_3x3_buffer;

  localparam int DW = 16;
  localparam int N  = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pulses;

  logic [9*DW-1:0] sb [$];

  window_3x3_buffer_if #(.DATA_WIDTH(DW)) bus ();

  window_3x3_buffer #(.DATA_WIDTH(DW), .IMG_SIZE(N)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int base, input int r, input int c);
    return DW'(base + N*(r-1) + c);
  endfunction

  // Expected window for pixel (r,c): slice 3*i+j is pixel (r-2+i, c-2+j).
  function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = pix(base, r-2+i, c-2+j);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive at negedge, accept at posedge, check 1ns later.
  task automatic step(input bit en, input int base, input int r, input int c);
    bit exp_v;
    bit exp_fd;
    @(negedge clk);
    bus.En      = en;
    bus.Data_In = en ? pix(base, r, c) : DW'($urandom);
    exp_v  = en && (r >= 3) && (c >= 3);
    exp_fd = en && (r == N) && (c == N);
    if (exp_v) sb.push_back(exp_win(base, r, c));
    @(posedge clk);
    #1;
    chk(en ? "out_valid" : "out_valid_idle", {143'd0, bus.Out_Valid}, {143'd0, exp_v});
    chk(en ? "frame_done" : "frame_done_idle", {143'd0, bus.Frame_Done}, {143'd0, exp_fd});
    if (bus.Out_Valid === 1'b1) begin
      pulses++;
      if (sb.size() > 0) chk("win_out", bus.Win_Out, sb.pop_front());
    end
  endtask

  // Feed pixels 1..upto of a frame, optionally with random idle cycles.
  task automatic frame(input int base, input bit gaps, input int upto);
    int n;
    n = 0;
    for (int r = 1; r <= N; r++) begin
      for (int c = 1; c <= N; c++) begin
        n++;
        if (n <= upto) begin
          if (gaps) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int g = 0; g < idle; g++) step(1'b0, base, r, c);
          end
          step(1'b1, base, r, c);
        end
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    pulses = 0;
    rst         = 1'b1;
    bus.En      = 1'b0;
    bus.Data_In = '0;
    #1;
    chk("reset_win", bus.Win_Out, '0);
    chk("reset_valid", {143'd0, bus.Out_Valid}, '0);
    chk("reset_done", {143'd0, bus.Frame_Done}, '0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous frame.
    pulses = 0;
    frame(0, 1'b0, N*N);
    chk("pulses_plain", 144'(pulses), 144'((N-2)*(N-2)));

    // Same frame with random idle cycles.
    pulses = 0;
    frame(0, 1'b1, N*N);
    chk("pulses_gaps", 144'(pulses), 144'((N-2)*(N-2)));

    // Two frames back-to-back, second offset by 100.
    pulses = 0;
    frame(0, 1'b0, N*N);
    frame(100, 1'b0, N*N);
    chk("pulses_b2b", 144'(pulses), 144'(2*(N-2)*(N-2)));

    // Partial frame, then asynchronous reset mid-cycle.
    frame(0, 1'b0, 17);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_win", bus.Win_Out, '0);
    chk("midreset_valid", {143'd0, bus.Out_Valid}, '0);
    chk("midreset_done", {143'd0, bus.Frame_Done}, '0);
    // En must be ignored while reset is held.
    @(negedge clk);
    bus.En      = 1'b1;
    bus.Data_In = 16'h00ff;
    @(posedge clk);
    #1;
    chk("rst_en_win", bus.Win_Out, '0);
    chk("rst_en_valid", {143'd0, bus.Out_Valid}, '0);
    @(negedge clk);
    bus.En = 1'b0;
    rst    = 1'b0;

    pulses = 0;
    frame(0, 1'b0, N*N);
    chk("pulses_after_rst", 144'(pulses), 144'((N-2)*(N-2)));
    chk("sb_empty", 144'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
